// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C byte controller.
// Command codes and controller state names.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        OWN,
        SHIFT,
        ACK,
        RSTART,
        STOP
    } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge detector for one bus line.
// Idle bus level is high, so all flops come out of reset at 1.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronize the line and keep one delayed copy for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/i2c_byte_controller.sv
// Byte-level I2C master: START, WRITE, READ, STOP on top of
// an external SCL generator, with slave clock stretching.
module i2c_byte_controller
    import i2c_pkg::*;
#(
    parameter int HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rdata,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       scl_en,
    output logic       scl_wait,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    logic sync_unused;

    state_e        state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          rd_q, rd_d;
    logic          nack_q, nack_d;
    logic          ack_q, ack_d;
    logic          sda_q, sda_d;
    logic          en_q, en_d;
    logic          rv_q, rv_d;
    logic          rn_q, rn_d;
    logic          re_q, re_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          hold_hit;

    i2c_line_sync u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (scl_i),
        .dout (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sda_i),
        .dout (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    assign sync_unused = scl_s ^ sda_rise ^ sda_fall;

    assign cmd_ready = (state_q == IDLE) || (state_q == OWN);
    // SCL is parked low while we own the bus and nothing is pending.
    assign scl_wait  = (state_q == OWN) && !cmd_valid;
    assign hold_hit  = (hcnt_q == HOLD_LAST);

    assign sda_o     = sda_q;
    assign scl_en    = en_q;
    assign rsp_valid = rv_q;
    assign rsp_nack  = rn_q;
    assign rsp_err   = re_q;
    assign rdata     = rdata_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            hcnt_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            rd_q    <= 1'b0;
            nack_q  <= 1'b0;
            ack_q   <= 1'b0;
            sda_q   <= 1'b1;
            en_q    <= 1'b0;
            rv_q    <= 1'b0;
            rn_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rd_q    <= rd_d;
            nack_q  <= nack_d;
            ack_q   <= ack_d;
            sda_q   <= sda_d;
            en_q    <= en_d;
            rv_q    <= rv_d;
            rn_q    <= rn_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, bus sequencing and response generation.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        hcnt_d  = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rd_d    = rd_q;
        nack_d  = nack_q;
        ack_d   = ack_q;
        sda_d   = sda_q;
        en_d    = en_q;
        rv_d    = 1'b0;
        rn_d    = 1'b0;
        re_d    = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ph_d   = '0;
                    hcnt_d = '0;
                    if (cmd_e'(cmd) == CMD_START) begin
                        state_d = START;
                        sda_d   = 1'b0;
                    end else begin
                        rv_d = 1'b1;
                        re_d = 1'b1;
                    end
                end
            end
            START: begin
                if (ph_q == 2'd0) begin
                    if (hold_hit) begin
                        en_d = 1'b1;
                        ph_d = 2'd1;
                    end
                end else if (scl_fall) begin
                    state_d = OWN;
                    rv_d    = 1'b1;
                end
            end
            OWN: begin
                if (cmd_valid) begin
                    ph_d   = '0;
                    hcnt_d = '0;
                    bit_d  = '0;
                    case (cmd_e'(cmd))
                        CMD_START: state_d = RSTART;
                        CMD_WRITE: begin
                            state_d = SHIFT;
                            rd_d    = 1'b0;
                            byte_d  = wdata;
                        end
                        CMD_READ: begin
                            state_d = SHIFT;
                            rd_d    = 1'b1;
                            nack_d  = cmd_nack;
                            sda_d   = 1'b1;
                        end
                        CMD_STOP:  state_d = STOP;
                        default:   state_d = OWN;
                    endcase
                end
            end
            SHIFT: begin
                if (!rd_q && hold_hit)
                    sda_d = byte_q[3'd7 - bit_q[2:0]];
                if (rd_q && scl_rise)
                    byte_d = {byte_q[6:0], sda_s};
                if (scl_fall) begin
                    hcnt_d = '0;
                    if (bit_q == 4'd7) begin
                        state_d = ACK;
                        bit_d   = 4'd8;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (hold_hit)
                    sda_d = rd_q ? nack_q : 1'b1;
                if (scl_rise)
                    ack_d = sda_s;
                if (scl_fall) begin
                    state_d = OWN;
                    bit_d   = '0;
                    rv_d    = 1'b1;
                    rn_d    = !rd_q && ack_q;
                    if (rd_q)
                        rdata_d = byte_q;
                end
            end
            RSTART: begin
                case (ph_q)
                    2'd0: if (hold_hit) begin
                        sda_d = 1'b1;
                        ph_d  = 2'd1;
                    end
                    2'd1: if (scl_rise) begin
                        hcnt_d = '0;
                        ph_d   = 2'd2;
                    end
                    2'd2: if (hold_hit) begin
                        sda_d = 1'b0;
                        ph_d  = 2'd3;
                    end
                    default: if (scl_fall) begin
                        state_d = OWN;
                        rv_d    = 1'b1;
                    end
                endcase
            end
            STOP: begin
                case (ph_q)
                    2'd0: if (hold_hit) begin
                        sda_d = 1'b0;
                        ph_d  = 2'd1;
                    end
                    2'd1: if (scl_rise) begin
                        hcnt_d = '0;
                        ph_d   = 2'd2;
                    end
                    default: if (hold_hit) begin
                        sda_d   = 1'b1;
                        en_d    = 1'b0;
                        state_d = IDLE;
                        rv_d    = 1'b1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_controller.sv
// Bench for i2c_byte_controller with an SCL generator model
// and an open-drain slave model that can stretch SCL.
module tb_i2c_byte_controller;

    localparam int SCL_DIV = 4;
    localparam int HALF    = 4 * SCL_DIV;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err;
    logic [7:0] rdata;
    logic       scl_en, scl_wait, sda_o;

    logic gen_scl = 1'b1;
    logic slave_scl = 1'b1;
    logic slave_sda = 1'b1;
    logic scl_line, sda_line;
    assign scl_line = gen_scl & slave_scl;
    assign sda_line = sda_o & slave_sda;

    int tests = 0;
    int fails = 0;

    i2c_byte_controller #(.HOLD_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wdata     (wdata),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .rsp_nack  (rsp_nack),
        .rsp_err   (rsp_err),
        .scl_en    (scl_en),
        .scl_wait  (scl_wait),
        .scl_i     (scl_line),
        .sda_i     (sda_line),
        .sda_o     (sda_o)
    );

    always #5 clk = ~clk;

    // SCL generator: half period HALF clocks, high phase waits
    // for the wired line so a stretching slave is honoured.
    int gcnt = 0;
    always @(posedge clk) begin
        if (!scl_en) begin
            gen_scl <= 1'b1;
            gcnt    <= 0;
        end else if (scl_wait) begin
            gen_scl <= 1'b0;
            gcnt    <= 0;
        end else if (!gen_scl) begin
            if (gcnt == HALF - 1) begin
                gen_scl <= 1'b1;
                gcnt    <= 0;
            end else gcnt <= gcnt + 1;
        end else if (scl_line) begin
            if (gcnt == HALF - 1) begin
                gen_scl <= 1'b0;
                gcnt    <= 0;
            end else gcnt <= gcnt + 1;
        end
    end

    // Slave: new SDA value on each SCL fall, optional stretch.
    logic drv_q[$];
    int   falls = 0;
    int   stretch_at = 0;
    always @(negedge scl_line) begin
        if (drv_q.size() != 0) slave_sda = drv_q.pop_front();
        else slave_sda = 1'b1;
        falls++;
        if (stretch_at != 0 && falls == stretch_at) begin
            stretch_at = 0;
            slave_scl  = 1'b0;
            repeat (50) @(posedge clk);
            slave_scl  = 1'b1;
        end
    end

    // SDA level seen at every SCL rise.
    logic rise_log[$];
    always @(posedge scl_line) rise_log.push_back(sda_line);

    // Bus conditions: SDA edges while SCL stays high.
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    int   starts = 0;
    int   stops = 0;
    int   pulses = 0;
    always @(negedge clk) begin
        if (scl_line && p_scl && sda_line !== p_sda) begin
            if (!sda_line) starts++;
            else stops++;
        end
        p_scl = scl_line;
        p_sda = sda_line;
        if (rsp_valid) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] wd,
                        input logic nk);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        wdata     = wd;
        cmd_nack  = nk;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        wdata     = 8'h00;
        cmd_nack  = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc, output logic [7:0] rd,
                            output logic nk, output logic er);
        cyc = 0;
        rd  = 8'h00;
        nk  = 1'b0;
        er  = 1'b0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = i;
                rd  = rdata;
                nk  = rsp_nack;
                er  = rsp_err;
                break;
            end
        end
        check("rsp_seen", 32'(cyc != 0), 32'd1);
    endtask

    task automatic load_slave(input logic [8:0] s);
        drv_q.delete();
        for (int i = 7; i >= 0; i--) drv_q.push_back(s[i]);
        slave_sda = s[8];
        falls     = 0;
    endtask

    task automatic do_start(input string tag);
        int cyc, s0, t0;
        logic [7:0] r;
        logic n, er;
        s0 = starts;
        t0 = stops;
        send(C_START, 8'h00, 1'b0);
        wait_rsp(cyc, r, n, er);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_nack"}, 32'(n), 32'd0);
        check({tag, "_scl_en"}, 32'(scl_en), 32'd1);
        check({tag, "_scl_wait"}, 32'(scl_wait), 32'd1);
        check({tag, "_starts"}, 32'(starts - s0), 32'd1);
        check({tag, "_stops"}, 32'(stops - t0), 32'd0);
    endtask

    task automatic do_stop(input string tag);
        int cyc, s0, t0;
        logic [7:0] r;
        logic n, er;
        s0 = starts;
        t0 = stops;
        send(C_STOP, 8'h00, 1'b0);
        wait_rsp(cyc, r, n, er);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_nack"}, 32'(n), 32'd0);
        check({tag, "_sda_o"}, 32'(sda_o), 32'd1);
        check({tag, "_scl_en"}, 32'(scl_en), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        #1;
        check({tag, "_stops"}, 32'(stops - t0), 32'd1);
        check({tag, "_starts"}, 32'(starts - s0), 32'd0);
    endtask

    // Byte transfer; bus line is the wired-AND of master and slave.
    task automatic xfer(input string tag, input logic rd,
                        input logic [7:0] b, input logic f,
                        input int stretch);
        logic [8:0] m, s, e, got;
        logic [7:0] r;
        logic n, er;
        int cyc, s0, t0;
        if (rd) begin
            m = {8'hFF, f};
            s = {b, 1'b1};
        end else begin
            m = {b, 1'b1};
            s = {8'hFF, ~f};
        end
        e = m & s;
        load_slave(s);
        rise_log.delete();
        s0 = starts;
        t0 = stops;
        stretch_at = stretch;
        send(rd ? C_READ : C_WRITE, rd ? 8'h00 : b, rd ? f : 1'b0);
        wait_rsp(cyc, r, n, er);
        got = '0;
        foreach (rise_log[i]) got = {got[7:0], rise_log[i]};
        check({tag, "_rises"}, 32'(rise_log.size()), 32'd9);
        check({tag, "_sda_bits"}, 32'(got), 32'(e));
        if (rd) begin
            check({tag, "_rdata"}, 32'(r), 32'(e[8:1]));
            check({tag, "_nack"}, 32'(n), 32'd0);
        end else begin
            check({tag, "_nack"}, 32'(n), 32'(e[0]));
        end
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_scl_wait"}, 32'(scl_wait), 32'd1);
        check({tag, "_starts"}, 32'(starts - s0), 32'd0);
        check({tag, "_stops"}, 32'(stops - t0), 32'd0);
        if (stretch != 0)
            check({tag, "_stretched"}, 32'(stretch_at), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, p0, n;
        logic [7:0] r, b;
        logic nk, er, rd, f;
        logic [1:0] bad [3];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sda_o", 32'(sda_o), 32'd1);
        check("rst_scl_en", 32'(scl_en), 32'd0);
        check("rst_scl_wait", 32'(scl_wait), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;

        bad[0] = C_WRITE;
        bad[1] = C_READ;
        bad[2] = C_STOP;
        foreach (bad[i]) begin
            send(bad[i], 8'h5A, 1'b0);
            wait_rsp(cyc, r, nk, er);
            check("v5_latency", 32'(cyc), 32'd1);
            check("v5_err", 32'(er), 32'd1);
            check("v5_nack", 32'(nk), 32'd0);
            repeat (5) @(negedge clk);
            check("v5_scl_en", 32'(scl_en), 32'd0);
            check("v5_sda_o", 32'(sda_o), 32'd1);
        end

        do_start("v1_start");
        xfer("v1_wr", 1'b0, 8'hA5, 1'b1, 0);
        do_stop("v1_stop");

        do_start("v2_start");
        xfer("v2_wr", 1'b0, 8'h3C, 1'b0, 0);
        repeat (5) @(negedge clk);
        check("v2_park", 32'(scl_wait), 32'd1);
        check("v2_own", 32'(cmd_ready), 32'd1);

        xfer("v3_rd", 1'b1, 8'h5A, 1'b1, 0);
        do_start("v3_rstart");
        xfer("v3_rd_ack", 1'b1, 8'hC3, 1'b0, 0);
        do_stop("v3_stop");

        do_start("v4_start");
        xfer("v4_wr", 1'b0, 8'hFF, 1'b1, 3);
        do_stop("v4_stop");

        do_start("rnd_start");
        for (int k = 0; k < 8; k++) begin
            rd = 1'($urandom_range(0, 1));
            b  = 8'($urandom);
            f  = 1'($urandom_range(0, 1));
            xfer("rnd", rd, b, f, 0);
            if ($urandom_range(0, 3) == 0) do_start("rnd_rstart");
        end
        do_stop("rnd_stop");

        do_start("v6_start");
        load_slave({8'h96, 1'b1});
        rise_log.delete();
        send(C_READ, 8'h00, 1'b1);
        n = 0;
        while (rise_log.size() < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("v6_bit4_reached", 32'(rise_log.size() >= 5), 32'd1);
        p0  = pulses;
        rst = 1'b1;
        drv_q.delete();
        slave_sda = 1'b1;
        @(negedge clk);
        check("v6_sda_o", 32'(sda_o), 32'd1);
        check("v6_scl_en", 32'(scl_en), 32'd0);
        check("v6_ready", 32'(cmd_ready), 32'd1);
        check("v6_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("v6_no_pulse", 32'(pulses - p0), 32'd0);

        do_start("post_start");
        xfer("post_wr", 1'b0, 8'($urandom), 1'b1, 0);
        do_stop("post_stop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_byte_controller.md
I2C_BYTE_CONTROLLER -- requirements
Module: i2c_byte_controller

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 4: clk cycles SDA is held stable after the SCL edge that precedes any SDA change.
REQ-002 SHALL have ports in this order:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd  in  2  command: 0 START, 1 WRITE, 2 READ, 3 STOP.
- wdata  in  8  WRITE byte, sent MSB first.
- cmd_nack  in  1  READ only: 1 means the master NACKs (releases SDA) on the 9th bit.
- rsp_valid  out  1  one-cycle completion pulse.
- rdata  out  8  READ result.
- rsp_nack  out  1  WRITE: SDA level sampled on the 9th bit.
- rsp_err  out  1  illegal command.
- scl_en  out  1  enable to scl_generator.
- scl_wait  out  1  hold request to scl_generator; while high, SCL is held low.
- scl_i  in  1  SCL line.
- sda_i  in  1  SDA line.
- sda_o  out  1  open-drain SDA drive: 0 pulls low, 1 releases.
REQ-003 The one clock and the synchronous active-high reset are fixed design decisions.

Function
REQ-004 SHALL pass scl_i and sda_i through 2-FF synchronizers; scl_rise and scl_fall SHALL be one-cycle pulses taken from the synchronized SCL.
REQ-005 SHALL implement states IDLE, START, OWN, SHIFT, ACK, RSTART, STOP.
REQ-006 cmd_ready SHALL be 1 only in IDLE and OWN.
REQ-007 In OWN, scl_en and scl_wait SHALL both be 1, so SCL is parked low.
REQ-008 SHALL drop scl_wait in the cycle a command is accepted in OWN.
REQ-009 IDLE + START: drive sda_o=0, wait HOLD_CYC cycles, set scl_en=1, wait for scl_fall, go to OWN, pulse rsp_valid.
REQ-010 IDLE + WRITE/READ/STOP: no bus activity; pulse rsp_valid with rsp_err=1 in the cycle after acceptance; stay in IDLE.
REQ-011 OWN + START (repeated start), state RSTART:
- HOLD_CYC cycles after acceptance, release SDA.
- Wait for scl_rise, then HOLD_CYC cycles.
- Drive sda_o=0.
- Wait for scl_fall, set scl_wait=1, go to OWN, pulse rsp_valid.
REQ-012 WRITE:
- Bit counter runs 0..8. For bits 0..7, sda_o = wdata[7-n] from HOLD_CYC cycles after the preceding SCL fall (or after acceptance for bit 0).
- wdata SHALL be latched on acceptance.
- Bit 8 (ACK state): release SDA, sample sda_i on scl_rise into rsp_nack.
REQ-013 READ:
- Release SDA for bits 0..7; shift sda_i in MSB first on each scl_rise.
- Bit 8: sda_o = cmd_nack (latched on acceptance).
REQ-014 WRITE/READ end: on the scl_fall that ends bit 8, set scl_wait=1, go to OWN, pulse rsp_valid; rdata SHALL be valid with the pulse.
REQ-015 STOP:
- Drive sda_o=0 HOLD_CYC cycles after acceptance.
- Wait for scl_rise, then HOLD_CYC cycles.
- Release SDA, set scl_en=0, go to IDLE, pulse rsp_valid.
REQ-016 Slave clock stretching: all SCL waits SHALL be edge-driven with no timeout; a stretched low period SHALL NOT advance the bit counter.
REQ-017 SDA SHALL change only while synchronized SCL is low, except the START/STOP/RSTART transitions.
REQ-018 rsp_valid SHALL NOT support backpressure; rsp_nack and rsp_err SHALL be 0 on every pulse where they do not apply.

Reset
REQ-019 While rst is high, the next edge SHALL set: state IDLE, sda_o=1, scl_en=0, scl_wait=0, cmd_ready=1, rsp_valid=0, rsp_nack=0, rsp_err=0, rdata=0x00, bit counter 0.
REQ-020 Reset mid-byte SHALL abort the transfer with no rsp_valid pulse.
REQ-021 Synchronizer flops SHALL reset to 1.

Structure
REQ-022 Package i2c_pkg SHALL hold the cmd encodings (CMD_START..CMD_STOP) and the state enum.
REQ-023 The synchronizer and edge detector SHALL be one sub-module, i2c_line_sync, instantiated once each for SCL and SDA.

Verification
REQ-024 The bench SHALL connect scl_generator (scl_div=4) and an open-drain slave model, and SHALL cover:
- V1: START, WRITE 0xA5 with slave ACK, STOP -> SDA at SCL rises 1,0,1,0,0,1,0,1; rsp_nack=0; afterwards scl_en=0, sda_o=1.
- V2: WRITE 0x3C with no slave ACK -> rsp_nack=1, state OWN, scl_wait=1.
- V3: READ with slave driving 0x5A, cmd_nack=1 -> rdata=0x5A; SDA high on the 9th rise.
- V4: slave holds SCL low 50 cycles during bit 3 of WRITE 0xFF -> no bit lost, all 8 data bits sampled as 1.
- V5: WRITE in IDLE -> rsp_err=1 one cycle after acceptance; scl_en stays 0.
- V6: rst pulsed during bit 4 of READ -> next cycle sda_o=1, scl_en=0; no rsp_valid; cmd_ready=1.
